fixed_predictor_decoder: RTL

//  Reconstructs FLAC FIXED-subframe audio samples from the residual stream

---
 rtl/fixed_predictor_decoder_pkg.sv | 29 ++
 rtl/fixed_prediction.sv | 54 +++++
 rtl/fixed_predictor_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fixed_predictor_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_predictor_decoder_pkg
//  Purpose  : Shared constants and FSM state encoding for the FLAC FIXED
//             subframe decoder (fixed_predictor_decoder + fixed_prediction).
//  Contents : c_FIXED_ORDER_MAX  highest legal fixed predictor order
//             c_DATA_W           default sample/residual width
//             c_ACC_W            default prediction accumulator width
//             c_ORDER_W          width of the predictor order field
//             c_COUNT_W          width of the block sample counter
//             state_t            IDLE / WARMUP / RESID
//  Revision : 1.0  initial release
// ============================================================================
package fixed_predictor_decoder_pkg;

    localparam int c_FIXED_ORDER_MAX = 4;
    localparam int c_DATA_W          = 16;
    localparam int c_ACC_W           = c_DATA_W + 4;
    localparam int c_ORDER_W         = 4;
    localparam int c_COUNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RESID  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_prediction.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_prediction
//  Purpose  : Combinational FLAC fixed predictor. Produces the order 0..4
//             prediction from the four most recent reconstructed samples.
//  Ports    : iOrder       in   4       predictor order (0..4, else 0)
//             iS1..iS4     in   DATA_W  history, iS1 = most recent, signed
//             oPrediction  out  ACC_W   signed prediction
//  Revision : 1.0  initial release
// ============================================================================
module fixed_prediction
    import fixed_predictor_decoder_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ACC_W  = c_ACC_W
) (
    input  logic [c_ORDER_W-1:0] iOrder,
    input  logic [DATA_W-1:0]    iS1,
    input  logic [DATA_W-1:0]    iS2,
    input  logic [DATA_W-1:0]    iS3,
    input  logic [DATA_W-1:0]    iS4,
    output logic [ACC_W-1:0]     oPrediction
);

    localparam int c_EXT_W = ACC_W - DATA_W;

    logic signed [ACC_W-1:0] w_s1;
    logic signed [ACC_W-1:0] w_s2;
    logic signed [ACC_W-1:0] w_s3;
    logic signed [ACC_W-1:0] w_s4;

    // Sign-extend history into the accumulator width so the weighted sums
    // (worst case |4s1|+|6s2|+|4s3|+|s4| = 15 * 2^(DATA_W-1)) cannot wrap.
    assign w_s1 = {{c_EXT_W{iS1[DATA_W-1]}}, iS1};
    assign w_s2 = {{c_EXT_W{iS2[DATA_W-1]}}, iS2};
    assign w_s3 = {{c_EXT_W{iS3[DATA_W-1]}}, iS3};
    assign w_s4 = {{c_EXT_W{iS4[DATA_W-1]}}, iS4};

    always_comb begin
        oPrediction = '0;
        case (iOrder)
            4'd1:    oPrediction = w_s1;
            4'd2:    oPrediction = (w_s1 <<< 1) - w_s2;
            4'd3:    oPrediction = ((w_s1 <<< 1) + w_s1)
                                 - ((w_s2 <<< 1) + w_s2) + w_s3;
            4'd4:    oPrediction = (w_s1 <<< 2)
                                 - ((w_s2 <<< 2) + (w_s2 <<< 1))
                                 + (w_s3 <<< 2) - w_s4;
            default: oPrediction = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fixed_predictor_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_predictor_decoder
//  Purpose  : Rebuilds FLAC FIXED-subframe samples from the Rice residual
//             stream. Per block: passes the warm-up samples verbatim, then
//             adds the fixed prediction to every residual. One registered
//             output per accepted input strobe; end of block flagged.
//  Ports    : iClock           in   1       clock, posedge
//             iReset           in   1       asynchronous active-high reset
//             iEnable          in   1       qualifies iStart / iSampleValid
//             iStart           in   1       begin block, latch order/size
//             iPredictorOrder  in   4       fixed order 0..4
//             iBlockSize       in   16      samples per block incl. warm-up
//             iSampleValid     in   1       iSample strobe
//             iSample          in   DATA_W  warm-up sample or residual
//             oSample          out  DATA_W  reconstructed sample
//             oValid           out  1       oSample strobe
//             oBlockDone       out  1       strobe with last sample of block
//             oError           out  1       sticky illegal-order flag
//  Revision : 1.0  initial release
// ============================================================================
module fixed_predictor_decoder
    import fixed_predictor_decoder_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ACC_W  = c_ACC_W
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iEnable,
    input  logic                 iStart,
    input  logic [c_ORDER_W-1:0] iPredictorOrder,
    input  logic [c_COUNT_W-1:0] iBlockSize,
    input  logic                 iSampleValid,
    input  logic [DATA_W-1:0]    iSample,
    output logic [DATA_W-1:0]    oSample,
    output logic                 oValid,
    output logic                 oBlockDone,
    output logic                 oError
);

    state_t r_state;
    state_t w_stateNext;

    logic [c_ORDER_W-1:0] r_order;
    logic [c_COUNT_W-1:0] r_size;
    logic [c_COUNT_W-1:0] r_count;
    logic [DATA_W-1:0]    r_s1;
    logic [DATA_W-1:0]    r_s2;
    logic [DATA_W-1:0]    r_s3;
    logic [DATA_W-1:0]    r_s4;

    logic                 w_startGo;
    logic                 w_orderBad;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_enterResid;
    logic [c_COUNT_W-1:0] w_countNext;
    logic [ACC_W-1:0]     w_pred;
    logic [ACC_W-1:0]     w_sampleExt;
    logic [DATA_W-1:0]    w_recon;

    fixed_prediction #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W)
    ) u_prediction (
        .iOrder      (r_order),
        .iS1         (r_s1),
        .iS2         (r_s2),
        .iS3         (r_s3),
        .iS4         (r_s4),
        .oPrediction (w_pred)
    );

    assign w_startGo   = iEnable & iStart;
    assign w_orderBad  = (iPredictorOrder > c_ORDER_W'(c_FIXED_ORDER_MAX));
    // A start in the same cycle as a sample strobe wins; the strobe is dropped.
    assign w_accept    = iEnable & iSampleValid & ~iStart & (r_state != ST_IDLE);
    assign w_countNext = r_count + c_COUNT_W'(1);
    assign w_last      = (r_count == r_size - c_COUNT_W'(1));
    assign w_enterResid = (r_state == ST_WARMUP) &&
                          (w_countNext == c_COUNT_W'(r_order));

    // Residual + prediction in accumulator width; the stream guarantees the
    // result fits DATA_W, so the upper bits are simply dropped.
    assign w_sampleExt = {{(ACC_W-DATA_W){iSample[DATA_W-1]}}, iSample};
    assign w_recon     = (r_state == ST_WARMUP) ? iSample
                                                : DATA_W'(w_sampleExt + w_pred);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_startGo) begin
            if (w_orderBad || (iBlockSize == '0)) begin
                w_stateNext = ST_IDLE;
            end else if (iPredictorOrder != '0) begin
                w_stateNext = ST_WARMUP;
            end else begin
                w_stateNext = ST_RESID;
            end
        end else if (w_accept) begin
            // A block no longer than its order ends while still in warm-up.
            if (w_last) begin
                w_stateNext = ST_IDLE;
            end else if (w_enterResid) begin
                w_stateNext = ST_RESID;
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_order    <= '0;
            r_size     <= '0;
            r_count    <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_s4       <= '0;
            oSample    <= '0;
            oValid     <= 1'b0;
            oBlockDone <= 1'b0;
            oError     <= 1'b0;
        end else begin
            oValid     <= 1'b0;
            oBlockDone <= 1'b0;
            if (w_startGo) begin
                r_count <= '0;
                r_s1    <= '0;
                r_s2    <= '0;
                r_s3    <= '0;
                r_s4    <= '0;
                if (w_orderBad) begin
                    oError <= 1'b1;
                end else begin
                    oError     <= 1'b0;
                    r_order    <= iPredictorOrder;
                    r_size     <= iBlockSize;
                    // An empty block completes immediately with no sample.
                    oBlockDone <= (iBlockSize == '0);
                end
            end else if (w_accept) begin
                oSample    <= w_recon;
                oValid     <= 1'b1;
                oBlockDone <= w_last;
                r_count    <= w_countNext;
                r_s4       <= r_s3;
                r_s3       <= r_s2;
                r_s2       <= r_s1;
                r_s1       <= w_recon;
            end
        end
    end

endmodule
`default_nettype wire
